// File: rtl/ra_stack.sv
// Return-address tracker: commits $r31 and predicts the target of `jr $r31` in DX.
// Define RA_STACK_EN for the circular return-address stack; otherwise only the forward path and ra_reg exist.
module ra_stack #(
  parameter int PTR_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             advance,
  input  logic             ra_enable,
  input  logic [31:0]      next_ra,
  input  logic             jal_XM,
  input  logic             jr_DX,
  output logic [31:0]      ra_out,
  output logic [31:0]      jr_target,
  output logic             jr_target_valid,
  output logic [PTR_W:0]   ra_count
);

  localparam int DEPTH = 2 ** PTR_W;

  logic [31:0] ra_reg;
  logic        commit;

  assign commit = advance && ra_enable;

  always_ff @(posedge clock) begin
    if (reset) begin
      ra_reg <= '0;
    end else if (commit) begin
      ra_reg <= next_ra;
    end
  end

  assign ra_out = ra_reg;

`ifdef RA_STACK_EN

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic [31:0]      stack [DEPTH];
  logic [PTR_W-1:0] top;
  logic [PTR_W-1:0] top_inc;
  logic [PTR_W:0]   count;
  logic             push;
  logic             overwrite;
  logic             pop;

  assign top_inc   = top + 1'b1;
  assign push      = commit && jal_XM;
  assign overwrite = commit && !jal_XM;
  assign pop       = advance && jr_DX;

  // A jal in XM is older than the jr in DX, so push+pop cancels to no change.
  always_ff @(posedge clock) begin
    if (reset) begin
      top   <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        stack[i] <= '0;
      end
    end else if (pop) begin
      if (!push && count != '0) begin
        top   <= top - 1'b1;
        count <= count - 1'b1;
      end
    end else if (push) begin
      top            <= top_inc;
      stack[top_inc] <= next_ra;
      if (count != DEPTH_C) begin
        count <= count + 1'b1;
      end
    end else if (overwrite && count != '0) begin
      stack[top] <= next_ra;
    end
  end

  always_comb begin
    jr_target       = ra_reg;
    jr_target_valid = 1'b0;
    if (ra_enable) begin
      jr_target       = next_ra;
      jr_target_valid = 1'b1;
    end else if (count != '0) begin
      jr_target       = stack[top];
      jr_target_valid = 1'b1;
    end
  end

  assign ra_count = count;

`else

  logic ra_written;
  logic unused_stack_inputs;

  assign unused_stack_inputs = jal_XM ^ jr_DX;

  always_ff @(posedge clock) begin
    if (reset) begin
      ra_written <= 1'b0;
    end else if (commit) begin
      ra_written <= 1'b1;
    end
  end

  assign jr_target       = ra_enable ? next_ra : ra_reg;
  assign jr_target_valid = ra_enable || ra_written;
  assign ra_count        = '0;

`endif

endmodule

// File: tb/tb_ra_stack.sv
// Directed scoreboard bench for ra_stack; expectations come from a behavioural model of the return-address stack.
module tb_ra_stack;

  localparam int PTR_W = 3;
  localparam int DEPTH = 8;

  logic         clock;
  logic         reset;
  logic         advance;
  logic         ra_enable;
  logic [31:0]  next_ra;
  logic         jal_XM;
  logic         jr_DX;
  logic [31:0]  ra_out;
  logic [31:0]  jr_target;
  logic         jr_target_valid;
  logic [PTR_W:0] ra_count;

  ra_stack #(.PTR_W(PTR_W)) dut (
    .clock           (clock),
    .reset           (reset),
    .advance         (advance),
    .ra_enable       (ra_enable),
    .next_ra         (next_ra),
    .jal_XM          (jal_XM),
    .jr_DX           (jr_DX),
    .ra_out          (ra_out),
    .jr_target       (jr_target),
    .jr_target_valid (jr_target_valid),
    .ra_count        (ra_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [31:0] tgt;
    logic        vld;
    logic [31:0] ra;
    logic [3:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state
  logic [31:0] m_ra;
  logic [31:0] m_stack [DEPTH];
  int          m_top;
  int          m_count;
  logic        m_written;

  task automatic model_reset();
    m_ra      = '0;
    m_top     = 0;
    m_count   = 0;
    m_written = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_stack[i] = '0;
  endtask

  task automatic model_update(input logic adv, input logic rst, input logic en,
                              input logic jal, input logic jr, input logic [31:0] val);
    if (rst) begin
      model_reset();
    end else if (adv) begin
      if (en) begin
        m_ra      = val;
        m_written = 1'b1;
      end
`ifdef RA_STACK_EN
      if (jr) begin
        if (!(en && jal) && m_count > 0) begin
          m_top   = (m_top + DEPTH - 1) % DEPTH;
          m_count = m_count - 1;
        end
      end else if (en && jal) begin
        m_top          = (m_top + 1) % DEPTH;
        m_stack[m_top] = val;
        if (m_count < DEPTH) m_count = m_count + 1;
      end else if (en && m_count > 0) begin
        m_stack[m_top] = val;
      end
`endif
    end
  endtask

  task automatic push_expected(input string tag);
    exp_t e;
    e.tag = tag;
    e.ra  = m_ra;
`ifdef RA_STACK_EN
    e.cnt = 4'(m_count);
    if (ra_enable) begin
      e.tgt = next_ra;
      e.vld = 1'b1;
    end else if (m_count > 0) begin
      e.tgt = m_stack[m_top];
      e.vld = 1'b1;
    end else begin
      e.tgt = m_ra;
      e.vld = 1'b0;
    end
`else
    e.cnt = 4'd0;
    e.tgt = ra_enable ? next_ra : m_ra;
    e.vld = ra_enable || m_written;
`endif
    exp_q.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = exp_q.pop_front();
    total++;
    assert (jr_target === e.tgt) else begin
      bad++;
      $error("[TB] FAIL %s jr_target observed=%h expected=%h", e.tag, jr_target, e.tgt);
    end
    total++;
    assert (jr_target_valid === e.vld) else begin
      bad++;
      $error("[TB] FAIL %s jr_target_valid observed=%b expected=%b", e.tag, jr_target_valid, e.vld);
    end
    total++;
    assert (ra_out === e.ra) else begin
      bad++;
      $error("[TB] FAIL %s ra_out observed=%h expected=%h", e.tag, ra_out, e.ra);
    end
    total++;
    assert (ra_count === e.cnt) else begin
      bad++;
      $error("[TB] FAIL %s ra_count observed=%0d expected=%0d", e.tag, ra_count, e.cnt);
    end
  endtask

  // One pipeline cycle: check combinational outputs before the edge, state after it.
  task automatic applyStimulus(input string tag, input logic adv, input logic rst,
                               input logic en, input logic jal, input logic jr,
                               input logic [31:0] val);
    @(negedge clock);
    reset     = rst;
    advance   = adv;
    ra_enable = en;
    jal_XM    = jal;
    jr_DX     = jr;
    next_ra   = val;
    #1;
    push_expected({tag, "/pre"});
    checkOutput();
    @(posedge clock);
    model_update(adv, rst, en, jal, jr, val);
    #1;
    push_expected({tag, "/post"});
    checkOutput();
  endtask

  initial begin
    reset     = 1'b1;
    advance   = 1'b0;
    ra_enable = 1'b0;
    jal_XM    = 1'b0;
    jr_DX     = 1'b0;
    next_ra   = '0;
    repeat (2) @(posedge clock);
    model_reset();
    $display("[TB] reset released");

    for (int i = 0; i < 3; i++) applyStimulus("idle", 1, 0, 0, 0, 0, 32'h0);

    applyStimulus("jal10", 1, 0, 1, 1, 0, 32'h10);
    applyStimulus("jal20", 1, 0, 1, 1, 0, 32'h20);
    applyStimulus("pop20", 1, 0, 0, 0, 1, 32'h0);
    applyStimulus("pop10", 1, 0, 0, 0, 1, 32'h0);

    for (int i = 1; i <= 9; i++) applyStimulus("jal_fill", 1, 0, 1, 1, 0, 32'(i));
    for (int i = 0; i < 9; i++) applyStimulus("pop_drain", 1, 0, 0, 0, 1, 32'h0);
    applyStimulus("underflow", 1, 0, 0, 0, 1, 32'h0);

    applyStimulus("jal30", 1, 0, 1, 1, 0, 32'h30);
    applyStimulus("jal44_pop", 1, 0, 1, 1, 1, 32'h44);
    applyStimulus("after_cancel", 1, 0, 0, 0, 0, 32'h0);
    applyStimulus("pop30", 1, 0, 0, 0, 1, 32'h0);

    applyStimulus("jal10b", 1, 0, 1, 1, 0, 32'h10);
    applyStimulus("jal20b", 1, 0, 1, 1, 0, 32'h20);
    applyStimulus("lw99_stall", 0, 0, 1, 0, 0, 32'h99);
    applyStimulus("stall_idle", 0, 0, 0, 0, 0, 32'h0);
    applyStimulus("lw99", 1, 0, 1, 0, 0, 32'h99);
    applyStimulus("after_lw", 1, 0, 0, 0, 0, 32'h0);
    applyStimulus("lw55_pop", 1, 0, 1, 0, 1, 32'h55);
    applyStimulus("pop_stall", 0, 0, 0, 0, 1, 32'h0);
    applyStimulus("after_ovw_pop", 1, 0, 0, 0, 0, 32'h0);

    applyStimulus("jal_reset", 1, 1, 1, 1, 0, 32'h77);
    applyStimulus("post_reset", 1, 0, 0, 0, 0, 32'h0);
    applyStimulus("lw_empty", 1, 0, 1, 0, 0, 32'h66);
    applyStimulus("after_lw_empty", 1, 0, 0, 0, 0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
